// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S / left-justified stereo DAC transmitter with one-pair holding register
module i2s_dac_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int CLK_DIV  = 2,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  input  logic                valid,
  output logic                ready,
  output logic                bck,
  output logic                lrck,
  output logic                din,
  output logic                frame_stb,
  output logic                underrun
);

  localparam int NBITS = 2 * SLOT_W;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(NBITS - 1);

  // Serial data bit for frame index idx: MSB first, zero padding past SAMPLE_W.
  // Shifting by p pushes the wanted bit into the MSB; p >= SAMPLE_W shifts it all out.
  function automatic logic bit_of(input logic [BW-1:0] idx,
                                  input logic [SAMPLE_W-1:0] fl,
                                  input logic [SAMPLE_W-1:0] fr);
    logic                ch;
    int                  p;
    logic [SAMPLE_W-1:0] w;
    ch = (int'(idx) >= SLOT_W);
    p  = ch ? int'(idx) - SLOT_W : int'(idx);
    w  = ch ? fr : fl;
    w  = w << p;
    return w[SAMPLE_W-1];
  endfunction

  // Word clock for frame index idx; I2S flips one bit ahead of the slot boundary.
  function automatic logic lrck_of(input logic [BW-1:0] idx);
    logic [BW-1:0] n;
    if (MODE == 0) begin
      n = (idx == B_LAST) ? '0 : idx + 1'b1;
    end else begin
      n = idx;
    end
    return (int'(n) >= SLOT_W);
  endfunction

  logic [DW-1:0]       div_q, div_d;
  logic                bck_q, bck_d;
  logic [BW-1:0]       b_q, b_d;
  logic                lrck_q, lrck_d;
  logic                din_q, din_d;
  logic [SAMPLE_W-1:0] frame_l_q, frame_l_d;
  logic [SAMPLE_W-1:0] frame_r_q, frame_r_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic                hold_full_q, hold_full_d;
  logic                stb_q, stb_d;
  logic                urun_q, urun_d;

  logic tick;
  logic fall;
  logic wrap;
  logic accept;

  // Timing events, handshake and next-state for prescaler, bit index, hold and frame.
  always_comb begin
    div_d       = div_q;
    bck_d       = bck_q;
    b_d         = b_q;
    lrck_d      = lrck_q;
    din_d       = din_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    stb_d       = 1'b0;
    urun_d      = 1'b0;

    tick = (div_q == DIV_LAST);
    fall = tick && bck_q;
    wrap = fall && (b_q == B_LAST);

    // The hold empties into the frame on a wrap, so it can take a new pair in that same cycle.
    ready  = !reset && (!hold_full_q || wrap);
    accept = valid && ready;

    div_d = tick ? '0 : div_q + 1'b1;
    if (tick) begin
      bck_d = ~bck_q;
    end

    if (wrap) begin
      stb_d = 1'b1;
      if (hold_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        frame_l_d = '0;
        frame_r_d = '0;
        urun_d    = 1'b1;
      end
    end

    if (accept) begin
      hold_l_d    = left;
      hold_r_d    = right;
      hold_full_d = 1'b1;
    end

    // din and lrck move together with the bit index, on the bck falling edge only.
    if (fall) begin
      b_d    = wrap ? '0 : b_q + 1'b1;
      din_d  = bit_of(b_d, frame_l_d, frame_r_d);
      lrck_d = lrck_of(b_d);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      bck_q       <= 1'b0;
      b_q         <= '0;
      lrck_q      <= lrck_of('0);
      din_q       <= 1'b0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      stb_q       <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      bck_q       <= bck_d;
      b_q         <= b_d;
      lrck_q      <= lrck_d;
      din_q       <= din_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      stb_q       <= stb_d;
      urun_q      <= urun_d;
    end
  end

  assign bck       = bck_q;
  assign lrck      = lrck_q;
  assign din       = din_q;
  assign frame_stb = stb_q;
  assign underrun  = urun_q;

endmodule
